// File: rtl/deserializer.sv
//==============================================================================
// Module      : deserializer
// Description : Collects an MSB-first, valid-qualified serial bit stream into
//               left-aligned parallel words; short words end on ser_last_i.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module deserializer #(
    parameter int WIDTH = 16,
    parameter int MOD_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic             ser_data_i,
    input  logic             ser_data_val_i,
    input  logic             ser_last_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic [MOD_W-1:0] deser_data_mod_o,
    output logic             deser_data_val_o,
    output logic             busy_o
);

    localparam logic [MOD_W-1:0] c_LAST_POS = MOD_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_sh;
    logic [MOD_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic [MOD_W-1:0] r_mod;
    logic             r_val;

    logic [MOD_W-1:0] w_pos;
    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_keep_mask;
    logic [WIDTH-1:0] w_sh_ins;
    logic             w_end;

    // Bit slot for the incoming bit; counter value 0 maps to the MSB.
    assign w_pos       = c_LAST_POS - r_cnt;
    assign w_bit_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << w_pos;
    assign w_keep_mask = {WIDTH{1'b1}} << w_pos;
    assign w_sh_ins    = (r_sh & ~w_bit_mask) | ({WIDTH{ser_data_i}} & w_bit_mask);
    assign w_end       = ser_data_val_i && ((r_cnt == c_LAST_POS) || ser_last_i);

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_mod  <= '0;
            r_val  <= 1'b0;
        end else begin
            r_val <= 1'b0;
            if (ser_data_val_i) begin
                if (w_end) begin
                    // Positions below the final bit were never written in this word.
                    r_data <= w_sh_ins & w_keep_mask;
                    r_mod  <= r_cnt + 1'b1;
                    r_val  <= 1'b1;
                    r_sh   <= '0;
                    r_cnt  <= '0;
                end else begin
                    r_sh   <= w_sh_ins;
                    r_cnt  <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign deser_data_o     = r_data;
    assign deser_data_mod_o = r_mod;
    assign deser_data_val_o = r_val;
    assign busy_o           = (r_cnt != '0);

endmodule

`default_nettype wire
